// File: rtl/i2c_byte_master.sv
// ---------------------------------------------------------------------------
// i2c_byte_master
//   Byte-level I2C master engine. Executes one command at a time (START,
//   WRITE byte, READ byte, STOP) on open-drain SDA/SCL and reports the
//   received byte and the slave ACK status.
//   SCL frequency = clk / (4*PRESCALE).
//
// Ports
//   clk        in     system clock
//   reset      in     synchronous, active-high reset (aborts, releases lines)
//   cmd_valid  in     command request
//   cmd_ready  out    engine idle, command accepted when cmd_valid & cmd_ready
//   cmd        in  2  0=START, 1=WRITE, 2=READ, 3=STOP
//   tx_byte    in  8  byte to send on WRITE (sampled at acceptance)
//   rd_nack    in     READ: 1 = NACK the byte, 0 = ACK (sampled at acceptance)
//   done       out    one-cycle pulse when the accepted command completes
//   rx_byte    out 8  byte from the most recent READ
//   ack_err    out    slave NACKed the most recent WRITE
//   bus_held   out    high between a completed START and a completed STOP
//   sda, scl   inout  open drain, driven to 0 or Z only
// ---------------------------------------------------------------------------
module i2c_byte_master #(
  parameter int PRESCALE = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_byte,
  input  logic       rd_nack,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       ack_err,
  output logic       bus_held,
  inout  wire        sda,
  inout  wire        scl
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  phase_reg, phase_next;
  logic [2:0]  bit_reg, bit_next;
  logic [1:0]  op_reg, op_next;
  logic [7:0]  shift_reg, shift_next;
  // READ: latched rd_nack. WRITE: sampled slave ACK bit during the ACK slot.
  logic        nack_reg, nack_next;
  logic        noop_reg, noop_next;
  logic        done_reg, done_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        ack_err_reg, ack_err_next;
  logic        bus_held_reg, bus_held_next;
  logic        sda_low_reg, sda_low_next;
  logic        scl_low_reg, scl_low_next;

  logic        qtick;
  logic        accept;
  logic        sda_in;

  assign sda_in    = sda;
  assign qtick     = (state_reg != IDLE) && (cnt_reg == 8'(PRESCALE - 1));
  // A no-op command still owns one cycle before its done pulse, so the
  // engine is not ready while it is pending or while done is showing.
  assign cmd_ready = (state_reg == IDLE) && !done_reg && !noop_reg;
  assign accept    = cmd_valid && cmd_ready;

  assign done      = done_reg;
  assign rx_byte   = rx_byte_reg;
  assign ack_err   = ack_err_reg;
  assign bus_held  = bus_held_reg;

  assign sda = sda_low_reg ? 1'b0 : 1'bz;
  assign scl = scl_low_reg ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      phase_reg    <= '0;
      bit_reg      <= '0;
      op_reg       <= '0;
      shift_reg    <= '0;
      nack_reg     <= 1'b0;
      noop_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rx_byte_reg  <= '0;
      ack_err_reg  <= 1'b0;
      bus_held_reg <= 1'b0;
      sda_low_reg  <= 1'b0;
      scl_low_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      bit_reg      <= bit_next;
      op_reg       <= op_next;
      shift_reg    <= shift_next;
      nack_reg     <= nack_next;
      noop_reg     <= noop_next;
      done_reg     <= done_next;
      rx_byte_reg  <= rx_byte_next;
      ack_err_reg  <= ack_err_next;
      bus_held_reg <= bus_held_next;
      sda_low_reg  <= sda_low_next;
      scl_low_reg  <= scl_low_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = '0;
    phase_next    = phase_reg;
    bit_next      = bit_reg;
    op_next       = op_reg;
    shift_next    = shift_reg;
    nack_next     = nack_reg;
    noop_next     = 1'b0;
    done_next     = 1'b0;
    rx_byte_next  = rx_byte_reg;
    ack_err_next  = ack_err_reg;
    bus_held_next = bus_held_reg;
    sda_low_next  = 1'b0;
    scl_low_next  = 1'b0;

    if (state_reg != IDLE) begin
      cnt_next = qtick ? 8'd0 : cnt_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        if (noop_reg) begin
          done_next = 1'b1;
        end else if (accept) begin
          op_next    = cmd;
          shift_next = tx_byte;
          nack_next  = rd_nack;
          phase_next = 2'd0;
          bit_next   = 3'd0;
          if (cmd == CMD_START) begin
            state_next = START;
          end else if (!bus_held_reg) begin
            noop_next = 1'b1;
          end else if (cmd == CMD_STOP) begin
            state_next = STOP;
          end else begin
            state_next = BIT;
          end
        end
      end

      START, STOP: begin
        if (qtick) begin
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) begin
            state_next    = IDLE;
            done_next     = 1'b1;
            bus_held_next = (state_reg == START);
          end
        end
      end

      BIT: begin
        if (qtick) begin
          phase_next = phase_reg + 2'd1;
          // Mid-high sample point for received data.
          if (phase_reg == 2'd1 && op_reg == CMD_READ) begin
            shift_next = {shift_reg[6:0], sda_in};
          end
          if (phase_reg == 2'd3) begin
            if (op_reg == CMD_WRITE) begin
              shift_next = {shift_reg[6:0], 1'b0};
            end
            bit_next = bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
              state_next = ACK;
            end
          end
        end
      end

      ACK: begin
        if (qtick) begin
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd1 && op_reg == CMD_WRITE) begin
            nack_next = sda_in;
          end
          if (phase_reg == 2'd3) begin
            state_next = IDLE;
            done_next  = 1'b1;
            if (op_reg == CMD_WRITE) begin
              ack_err_next = nack_reg;
            end else begin
              rx_byte_next = shift_reg;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Pin drive is decoded from the next state so the registered pins line
    // up exactly with the phase they belong to.
    case (state_next)
      IDLE: begin
        // While the bus is held the master parks SCL low.
        scl_low_next = bus_held_next;
      end
      START: begin
        case (phase_next)
          2'd0:    scl_low_next = bus_held_reg;  // repeated START: SCL still low
          2'd1:    scl_low_next = 1'b0;
          2'd2:    sda_low_next = 1'b1;          // SDA falls while SCL high
          default: begin
            sda_low_next = 1'b1;
            scl_low_next = 1'b1;
          end
        endcase
      end
      STOP: begin
        case (phase_next)
          2'd0: begin
            sda_low_next = 1'b1;
            scl_low_next = 1'b1;
          end
          2'd1:    sda_low_next = 1'b1;          // SCL rises with SDA low
          default: sda_low_next = 1'b0;          // SDA rises last
        endcase
      end
      BIT: begin
        scl_low_next = (phase_next == 2'd0) || (phase_next == 2'd3);
        sda_low_next = (op_next == CMD_WRITE) && !shift_next[7];
      end
      ACK: begin
        scl_low_next = (phase_next == 2'd0) || (phase_next == 2'd3);
        sda_low_next = (op_next == CMD_READ) && !nack_next;
      end
      default: begin
        sda_low_next = 1'b0;
        scl_low_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_master
//   Directed bench for i2c_byte_master with a simple slave model, a bus
//   monitor and a scoreboard of expected command results.
// ---------------------------------------------------------------------------
module tb_i2c_byte_master;

  localparam int P = 18;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_byte;
  logic       rd_nack;
  logic       done;
  logic [7:0] rx_byte;
  logic       ack_err;
  logic       bus_held;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  always #5 clk = ~clk;

  i2c_byte_master #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .tx_byte(tx_byte), .rd_nack(rd_nack), .done(done),
    .rx_byte(rx_byte), .ack_err(ack_err), .bus_held(bus_held),
    .sda(sda), .scl(scl)
  );

  // Slave model: mode 0 silent, 1 ACKs writes, 2 NACKs writes, 3 sends slave_byte.
  logic [1:0] slave_mode;
  logic [7:0] slave_byte;
  logic [3:0] slot = 4'hf;
  logic       scl_s = 1'b1;
  logic       slave_low;

  always @(posedge clk) begin
    scl_s <= scl;
    if (cmd_valid && cmd_ready) slot <= 4'd0;
    else if (scl_s && !scl && slot != 4'hf) slot <= slot + 4'd1;
  end

  always_comb begin
    slave_low = 1'b0;
    if (slave_mode == 2'd1 && slot == 4'd8) slave_low = 1'b1;
    if (slave_mode == 2'd3 && slot < 4'd8) slave_low = !slave_byte[3'd7 - slot[2:0]];
  end

  assign sda = slave_low ? 1'b0 : 1'bz;

  // Bus monitor.
  logic        scl_q = 1'b1, sda_q = 1'b1;
  int          hi_cnt = 0, last_high = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic [15:0] rise_bits = '0;

  always @(posedge clk) begin
    scl_q <= scl;
    sda_q <= sda;
    if (scl && !scl_q) begin
      rise_cnt  <= rise_cnt + 1;
      rise_bits <= {rise_bits[14:0], sda};
    end
    if (scl && scl_q && !sda && sda_q) start_cnt <= start_cnt + 1;
    if (scl && scl_q && sda && !sda_q) stop_cnt <= stop_cnt + 1;
    if (scl) hi_cnt <= hi_cnt + 1;
    else begin
      if (hi_cnt != 0) last_high <= hi_cnt;
      hi_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic [7:0] rx;
    logic       ack;
    logic       held;
  } exp_t;

  exp_t       sb[$];
  logic       m_held = 1'b0;
  logic       m_ack  = 1'b0;
  logic [7:0] m_rx   = 8'h00;

  task automatic issue(input logic [1:0] c, input logic [7:0] b, input logic nk);
    exp_t e;
    int   w;
    if (c == 2'd0) begin
      e.lat = 4 * P; m_held = 1'b1;
    end else if (!m_held) begin
      e.lat = 1;
    end else if (c == 2'd3) begin
      e.lat = 4 * P; m_held = 1'b0;
    end else begin
      e.lat = 36 * P;
      if (c == 2'd1) m_ack = (slave_mode == 2'd2);
      else m_rx = slave_byte;
    end
    e.rx = m_rx; e.ack = m_ack; e.held = m_held;
    sb.push_back(e);
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd = c; tx_byte = b; rd_nack = nk; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    exp_t e;
    int   k;
    bit   seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40 * P + 100) begin
      @(posedge clk);
      k++;
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_latency"}, k, e.lat);
    check({tag, "_rx_byte"}, rx_byte, e.rx);
    check({tag, "_ack_err"}, ack_err, e.ack);
    check({tag, "_bus_held"}, bus_held, e.held);
    $display("txn %s: latency %0d rx_byte %02h ack_err %0b bus_held %0b", tag, k, rx_byte, ack_err, bus_held);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap_a, snap_b, dcount;
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; tx_byte = 8'h00; rd_nack = 1'b0;
    slave_mode = 2'd0; slave_byte = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // 1. Idle after reset
    repeat (100) @(posedge clk);
    #1;
    check("idle_sda", sda, 1);
    check("idle_scl", scl, 1);
    check("idle_ready", cmd_ready, 1);
    check("idle_done", done, 0);
    check("idle_held", bus_held, 0);
    check("idle_rx", rx_byte, 0);
    check("idle_ack", ack_err, 0);

    // 2. START, WRITE 0xA5 with slave ACK
    issue(2'd0, 8'h00, 1'b0);
    finish_cmd("start1");
    slave_mode = 2'd1;
    snap_a = start_cnt + stop_cnt;
    issue(2'd1, 8'hA5, 1'b0);
    finish_cmd("wr_a5");
    check("wr_a5_bits", rise_bits[8:1], 8'hA5);
    check("wr_a5_ackbit", rise_bits[0], 0);
    check("wr_a5_sda_stable", start_cnt + stop_cnt - snap_a, 0);
    check("wr_a5_scl_high", last_high, 2 * P);

    // 3. WRITE 0x3C with slave NACK, then STOP
    slave_mode = 2'd2;
    issue(2'd1, 8'h3C, 1'b0);
    finish_cmd("wr_3c");
    check("wr_3c_bits", rise_bits[8:1], 8'h3C);
    check("wr_3c_ackbit", rise_bits[0], 1);
    slave_mode = 2'd0;
    snap_a = stop_cnt;
    issue(2'd3, 8'h00, 1'b0);
    finish_cmd("stop1");
    check("stop1_condition", stop_cnt - snap_a, 1);
    check("stop1_sda", sda, 1);
    check("stop1_scl", scl, 1);

    // 4. READ 0x5E with NACK, READ 0xC3 with ACK
    issue(2'd0, 8'h00, 1'b0);
    finish_cmd("start2");
    slave_mode = 2'd3; slave_byte = 8'h5E;
    issue(2'd2, 8'h00, 1'b1);
    finish_cmd("rd_5e");
    check("rd_5e_bus_bits", rise_bits[8:1], 8'h5E);
    check("rd_5e_ack_slot", rise_bits[0], 1);
    slave_byte = 8'hC3;
    issue(2'd2, 8'h00, 1'b0);
    finish_cmd("rd_c3");
    check("rd_c3_ack_slot", rise_bits[0], 0);

    // 5. Reset halfway through a WRITE
    slave_mode = 2'd1;
    issue(2'd1, 8'h81, 1'b0);
    repeat (18 * P) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_held", bus_held, 0);
    check("rst_done", done, 0);
    @(negedge clk) reset = 1'b0;
    sb.delete();
    m_held = 1'b0; m_ack = 1'b0; m_rx = 8'h00;
    slave_mode = 2'd0;
    dcount = 0;
    repeat (40 * P) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("rst_no_done", dcount, 0);
    $display("txn reset_abort: done pulses after reset %0d", dcount);

    // 6. WRITE without bus, then START + repeated START
    snap_a = rise_cnt;
    issue(2'd1, 8'h55, 1'b0);
    finish_cmd("noop_wr");
    check("noop_scl_edges", rise_cnt - snap_a, 0);
    issue(2'd0, 8'h00, 1'b0);
    finish_cmd("start3");
    snap_a = rise_cnt;
    snap_b = start_cnt;
    issue(2'd0, 8'h00, 1'b0);
    finish_cmd("rep_start");
    check("rep_start_scl_rise", rise_cnt - snap_a, 1);
    check("rep_start_condition", start_cnt - snap_b, 1);
    issue(2'd3, 8'h00, 1'b0);
    finish_cmd("stop2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
